// File: rtl/vga_driver.sv
`default_nettype none
// ============================================================================
// Module   : vga_driver
// Purpose  : VGA timing master. Generates the sync/enable pins and requests
//            pixels one cycle ahead of the active window.
//            Optional frame counter output enabled by `define VGA_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_driver #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        vga_rst_n,
    input  logic [11:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        data_req,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0]  frame_cnt,
`endif
    output logic [11:0] vga_rgb
);

    localparam int H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HS_START = H_SYNC + H_BACK;
    localparam int VS_START = V_SYNC + V_BACK;

    localparam logic [10:0] c_h_last   = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_v_last   = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_h_sync   = 11'(H_SYNC);
    localparam logic [10:0] c_v_sync   = 11'(V_SYNC);
    localparam logic [10:0] c_de_h_lo  = 11'(HS_START);
    localparam logic [10:0] c_de_h_hi  = 11'(HS_START + H_DISP);
    localparam logic [10:0] c_req_h_lo = 11'(HS_START - 1);
    localparam logic [10:0] c_req_h_hi = 11'(HS_START + H_DISP - 1);
    localparam logic [10:0] c_v_lo     = 11'(VS_START);
    localparam logic [10:0] c_v_hi     = 11'(VS_START + V_DISP);

    logic        r_run;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [10:0] w_h_nxt;
    logic [10:0] w_v_nxt;
    logic        w_v_act;
    logic        w_de_nxt;
    logic        w_req_nxt;

    assign h_disp = 11'(H_DISP);
    assign v_disp = 11'(V_DISP);

    // Pins are registered from the next counter values so each pin lines up
    // with the counter value of the same cycle. The first clock after reset
    // holds the counters at 0 instead of advancing.
    always_comb begin
        w_h_wrap  = r_run && (r_h_cnt == c_h_last);
        w_v_wrap  = w_h_wrap && (r_v_cnt == c_v_last);
        w_h_nxt   = (!r_run || w_h_wrap) ? 11'd0 : r_h_cnt + 11'd1;
        w_v_nxt   = r_v_cnt;
        if (!r_run || w_v_wrap) begin
            w_v_nxt = 11'd0;
        end else if (w_h_wrap) begin
            w_v_nxt = r_v_cnt + 11'd1;
        end
        w_v_act   = (w_v_nxt >= c_v_lo) && (w_v_nxt < c_v_hi);
        w_de_nxt  = w_v_act && (w_h_nxt >= c_de_h_lo) && (w_h_nxt < c_de_h_hi);
        w_req_nxt = w_v_act && (w_h_nxt >= c_req_h_lo) && (w_h_nxt < c_req_h_hi);
    end

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_run      <= 1'b0;
            r_h_cnt    <= 11'd0;
            r_v_cnt    <= 11'd0;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            vga_de     <= 1'b0;
            data_req   <= 1'b0;
            vga_rgb    <= 12'd0;
            pixel_xpos <= 11'd0;
            pixel_ypos <= 11'd0;
        end else begin
            r_run      <= 1'b1;
            r_h_cnt    <= w_h_nxt;
            r_v_cnt    <= w_v_nxt;
            vga_hs     <= (w_h_nxt >= c_h_sync);
            vga_vs     <= (w_v_nxt >= c_v_sync);
            vga_de     <= w_de_nxt;
            data_req   <= w_req_nxt;
            // Blanking forces black regardless of what the generator returns.
            vga_rgb    <= w_de_nxt ? pixel_data : 12'd0;
            pixel_xpos <= w_req_nxt ? (w_h_nxt - c_req_h_lo) : 11'd0;
            pixel_ypos <= w_req_nxt ? (w_v_nxt - c_v_lo) : 11'd0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            frame_cnt <= 8'd0;
        end else if (w_v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_driver
// Purpose  : Self-checking bench for vga_driver using a reduced timing set and
//            a modulo-arithmetic reference model with randomized pixel sources.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_driver;

    localparam int HSY = 3;
    localparam int HBK = 2;
    localparam int HD  = 8;
    localparam int HFR = 3;
    localparam int VSY = 2;
    localparam int VBK = 2;
    localparam int VD  = 5;
    localparam int VFR = 3;
    localparam int HT  = HSY + HBK + HD + HFR;
    localparam int VT  = VSY + VBK + VD + VFR;
    localparam int FT  = HT * VT;
    localparam int HS  = HSY + HBK;
    localparam int VS  = VSY + VBK;
`ifdef VGA_FRAME_CNT_EN
    localparam int NFR = 258;
`else
    localparam int NFR = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [11:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        data_req;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [11:0] vga_rgb;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
`endif

    vga_driver #(
        .H_SYNC(HSY), .H_BACK(HBK), .H_DISP(HD), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_DISP(VD), .V_FRONT(VFR)
    ) dut (
        .vga_clk    (clk),
        .vga_rst_n  (rst_n),
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .data_req   (data_req),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_de     (vga_de),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .vga_rgb    (vga_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel generator: 0 = random table, 1 = constant white, 2 = column index
    int          mode;
    logic [11:0] lut [0:HD*VD-1];
    int          gen_idx;

    always_comb begin
        gen_idx = int'(pixel_ypos) * HD + int'(pixel_xpos);
        case (mode)
            1:       pixel_data = 12'hFFF;
            2:       pixel_data = {1'b0, pixel_xpos};
            default: pixel_data = (gen_idx < HD*VD) ? lut[gen_idx] : 12'd0;
        endcase
    end

    int vectors;
    int miscompares;
    int n;
    int hs_low_line;
    int req_line;
    int vs_low_frame;
    int req_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (index %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [11:0] model_pix(input int x, input int y);
        case (mode)
            1:       return 12'hFFF;
            2:       return 12'(x);
            default: return lut[y*HD + x];
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_hs"},    vga_hs,     1);
        chk({tag, "_vs"},    vga_vs,     1);
        chk({tag, "_de"},    vga_de,     0);
        chk({tag, "_req"},   data_req,   0);
        chk({tag, "_rgb"},   vga_rgb,    0);
        chk({tag, "_xpos"},  pixel_xpos, 0);
        chk({tag, "_ypos"},  pixel_ypos, 0);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_fcnt"},  frame_cnt,  0);
`endif
    endtask

    task automatic clear_counts();
        hs_low_line  = 0;
        req_line     = 0;
        vs_low_frame = 0;
        req_frame    = 0;
    endtask

    // Advance one pixel clock and compare every pin with the model at index n,
    // where n counts clocks since reset release (first clock is index 0).
    task automatic step_check();
        int  h, v;
        bit  vact, de, req;
        @(negedge clk);
        h    = n % HT;
        v    = (n / HT) % VT;
        vact = (v >= VS) && (v < VS + VD);
        de   = vact && (h >= HS) && (h < HS + HD);
        req  = vact && (h >= HS - 1) && (h < HS + HD - 1);
        chk("hs",   vga_hs,     (h >= HSY) ? 1 : 0);
        chk("vs",   vga_vs,     (v >= VSY) ? 1 : 0);
        chk("de",   vga_de,     de ? 1 : 0);
        chk("req",  data_req,   req ? 1 : 0);
        chk("xpos", pixel_xpos, req ? h - (HS - 1) : 0);
        chk("ypos", pixel_ypos, req ? v - VS : 0);
        chk("rgb",  vga_rgb,    de ? 32'(model_pix(h - HS, v - VS)) : 0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, (n / FT) % 256);
`endif
        if (!vga_hs)  hs_low_line++;
        if (!vga_vs)  vs_low_frame++;
        if (data_req) begin
            req_line++;
            req_frame++;
        end
        if (h == HT - 1) begin
            chk("hs_low_per_line", hs_low_line, HSY);
            chk("req_per_line", req_line, vact ? HD : 0);
            hs_low_line = 0;
            req_line    = 0;
            if (v == VT - 1) begin
                chk("vs_low_per_frame", vs_low_frame, VSY * HT);
                chk("req_per_frame", req_frame, HD * VD);
                vs_low_frame = 0;
                req_frame    = 0;
            end
        end
        n++;
    endtask

    task automatic run_frame();
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < HD*VD; i++) lut[i] = 12'($urandom);
        repeat (FT) step_check();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n           = 0;
        mode        = 0;
        for (int i = 0; i < HD*VD; i++) lut[i] = 12'($urandom);
        clear_counts();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        chk("h_disp", h_disp, HD);
        chk("v_disp", v_disp, VD);
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++) run_frame();

        // Stop mid-line inside the active window, then reset between edges.
        while ((n % FT) != (6 * HT + 10)) step_check();
        chk("pre_reset_de", vga_de, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        @(posedge clk);
        @(negedge clk);
        check_reset("held");
        rst_n = 1'b1;
        n = 0;
        clear_counts();

        for (int f = 0; f < NFR; f++) run_frame();
        step_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
